// File: rtl/counter_defs.sv
// Shared definitions for the count-to-BCD path: FSM encoding, digit width and
// a constant helper used for the parameter legality check.
package counter_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam int digit_w = 4;

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
   import counter_defs::*;
(
   input  logic [digit_w-1:0] din,
   output logic [digit_w-1:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) dout = din + 4'd3;
   end

endmodule

// File: rtl/count_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/busy/done handshake for the display/monitor stage.
//
// state | meaning
// IDLE  | waiting for start; bcd holds the last result
// SHIFT | sz correction+shift steps on {scratch, binreg}
// DONE  | publish scratch to bcd and pulse done
module count_bcd_converter
   import counter_defs::*;
#(
   parameter int sz = 8,
   parameter int nd = 3
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [sz-1:0]         bin,
   output logic                  busy,
   output logic                  done,
   output logic [digit_w*nd-1:0] bcd
);

   localparam int bw = digit_w * nd;
   localparam int cw = $clog2(sz + 1);

   generate
      if (pow10(nd) <= ((longint'(1) << sz) - 1)) begin : g_bad_params
         $error("count_bcd_converter: nd digits cannot represent every sz-bit value");
      end
   endgenerate

   conv_state_t state, state_nx;

   logic [sz-1:0]    binreg;
   logic [bw-1:0]    scratch;
   logic [bw-1:0]    adj;
   logic [cw-1:0]    cnt;
   logic [bw+sz-1:0] shifted;

   for (genvar g = 0; g < nd; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (scratch[g*digit_w +: digit_w]),
         .dout (adj[g*digit_w +: digit_w])
      );
   end

   // Bits leaving the top digit are dropped; the nd check guarantees they are zero.
   assign shifted = {adj, binreg} << 1;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == cw'(1)) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         binreg  <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd     <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  binreg  <= bin;
                  scratch <= '0;
                  cnt     <= cw'(sz);
               end
            end
            SHIFT: begin
               scratch <= shifted[bw+sz-1:sz];
               binreg  <= shifted[sz-1:0];
               cnt     <= cnt - cw'(1);
            end
            DONE: begin
               bcd  <= scratch;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_count_bcd_converter.sv
// Self-checking bench for count_bcd_converter: directed handshake scenarios plus
// randomized values against a decimal reference model.
module tb_count_bcd_converter;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;

   int n_checks;
   int n_fail;

   logic [7:0] mode_cnt;
   logic       cnt_up;

   count_bcd_converter #(.sz(8), .nd(3)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stand-in for the upstream mode counter, count-up mode
   always @(posedge clk) begin
      if (reset)       mode_cnt <= 8'd0;
      else if (cnt_up) mode_cnt <= mode_cnt + 8'd1;
   end

   function automatic logic [11:0] to_bcd(input int v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one conversion and observe 30 edges after the accepting edge.
   task automatic convert(input logic [7:0] v, output logic [11:0] res,
                          output int bcycles, output int dcount, output int lat);
      bin   = v;
      start = 1'b1;
      tick();
      start   = 1'b0;
      bcycles = 0;
      dcount  = 0;
      lat     = -1;
      res     = 12'hxxx;
      for (int k = 0; k < 30; k++) begin
         if (busy === 1'b1) bcycles++;
         if (done === 1'b1) begin
            dcount++;
            res = bcd;
            if (lat < 0) lat = k;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      bin   = 8'd0;
      cnt_up = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++;
      if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h exp 000", bcd); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single(input logic [7:0] v, input string nm);
      logic [11:0] res;
      int bc, dc, lat;
      convert(v, res, bc, dc, lat);
      n_checks++;
      if (res !== to_bcd(int'(v))) begin n_fail++; $display("FAIL %s_bcd got %h exp %h", nm, res, to_bcd(int'(v))); end
      n_checks++;
      if (bc !== 9) begin n_fail++; $display("FAIL %s_busy_cycles got %0d exp 9", nm, bc); end
      n_checks++;
      if (dc !== 1) begin n_fail++; $display("FAIL %s_done_count got %0d exp 1", nm, dc); end
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL %s_latency got %0d exp 9", nm, lat); end
      n_checks++;
      if (busy !== 1'b0 || bcd !== to_bcd(int'(v))) begin
         n_fail++; $display("FAIL %s_hold got busy=%b bcd=%h exp busy=0 bcd=%h", nm, busy, bcd, to_bcd(int'(v)));
      end
   endtask

   task automatic test_ignore_busy();
      int dc;
      logic [11:0] res;
      bin   = 8'd99;
      start = 1'b1;
      tick();
      start = 1'b0;
      dc    = 0;
      res   = 12'hxxx;
      for (int k = 0; k < 30; k++) begin
         if (k == 2) begin bin = 8'd200; start = 1'b1; end
         if (k == 5) start = 1'b0;
         if (done === 1'b1) begin dc++; res = bcd; end
         tick();
      end
      n_checks++;
      if (res !== 12'h099) begin n_fail++; $display("FAIL ignore_bcd got %h exp 099", res); end
      n_checks++;
      if (dc !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d exp 1", dc); end
   endtask

   task automatic test_back_to_back();
      int first_k, second_k, extra;
      logic [11:0] r1, r2;
      first_k  = -1;
      second_k = -1;
      extra    = 0;
      r1 = 12'hxxx;
      r2 = 12'hxxx;
      bin   = 8'd128;
      start = 1'b1;
      tick();
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) begin
            if (first_k < 0) begin
               first_k = k; r1 = bcd; bin = 8'd37;
            end else if (second_k < 0) begin
               second_k = k; r2 = bcd;
            end else extra++;
         end
         tick();
         if (first_k >= 0) start = 1'b0;
      end
      start = 1'b0;
      n_checks++;
      if (r1 !== 12'h128) begin n_fail++; $display("FAIL b2b_first got %h exp 128", r1); end
      n_checks++;
      if (r2 !== 12'h037) begin n_fail++; $display("FAIL b2b_second got %h exp 037", r2); end
      n_checks++;
      if (second_k - first_k !== 10) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 10", second_k - first_k); end
      n_checks++;
      if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_done got %0d exp 0", extra); end
   endtask

   task automatic test_reset_abort();
      int dc, bc, lat;
      logic [11:0] res;
      bin   = 8'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
         n_fail++; $display("FAIL abort_state got busy=%b done=%b bcd=%h exp 0 0 000", busy, done, bcd);
      end
      dc = 0;
      for (int k = 0; k < 20; k++) begin
         if (done === 1'b1 || busy === 1'b1) dc++;
         tick();
      end
      n_checks++;
      if (dc !== 0) begin n_fail++; $display("FAIL abort_activity got %0d exp 0", dc); end
      n_checks++;
      if (bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got %h exp 000", bcd); end
      convert(8'd5, res, bc, dc, lat);
      n_checks++;
      if (res !== 12'h005 || dc !== 1) begin n_fail++; $display("FAIL abort_restart got %h/%0d exp 005/1", res, dc); end
   endtask

   task automatic test_counter_sweep();
      logic [11:0] res;
      int bc, dc, lat;
      for (int i = 0; i <= 20; i++) begin
         convert(mode_cnt, res, bc, dc, lat);
         n_checks++;
         if (res !== to_bcd(i) || dc !== 1) begin
            n_fail++; $display("FAIL sweep_%0d got %h/%0d exp %h/1", i, res, dc, to_bcd(i));
         end
         cnt_up = 1'b1;
         tick();
         cnt_up = 1'b0;
      end
   endtask

   task automatic test_random();
      logic [11:0] res;
      logic [7:0]  v;
      int bc, dc, lat;
      for (int i = 0; i < 16; i++) begin
         v = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) tick();
         convert(v, res, bc, dc, lat);
         n_checks++;
         if (res !== to_bcd(int'(v)) || dc !== 1 || lat !== 9) begin
            n_fail++; $display("FAIL random_%0d got %h/%0d/%0d exp %h/1/9 for bin %0d", i, res, dc, lat, to_bcd(int'(v)), v);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single(8'd0, "zero");
      test_single(8'd255, "max");
      test_ignore_busy();
      test_back_to_back();
      test_reset_abort();
      test_counter_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
